// File: rtl/threshold_pkg.sv
// threshold_pkg: shared FSM encoding, default threshold and pipeline depth for threshold_table
package threshold_pkg;
    typedef enum logic {INIT, RUN} state_t;
    localparam logic [7:0] INIT_VALUE_DEF = 8'h80;
    localparam int PIPE_DEPTH = 2;
endpackage

// File: rtl/threshold_ram.sv
// threshold_ram: simple dual-port RAM; ports clock, we/waddr/wdata (sync write), re/raddr/rdata (registered read, held when re=0)
module threshold_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/threshold_table.sv
// threshold_table: writable per-block threshold table with self-init and a 2-stage valid/ready read pipeline
// ports: clock/reset; rd_valid/rd_ready/rd_addr read request; out_valid/out_ready/out_data/out_oob result;
//        wr_en/wr_addr/wr_data unhandshaked update; busy while clearing after reset
module threshold_table
    import threshold_pkg::*;
#(
    parameter int              ADDR_W     = 14,
    parameter int              DATA_W     = 8,
    parameter int              DEPTH      = 2**ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(INIT_VALUE_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_oob,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(DEPTH);
    state_t state, state_nx;
    logic [ADDR_W-1:0] clr_cnt;
    logic en, acc, rd_in, wr_in, wr_take, ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata, ram_q, s1_fwd_data, s1_data;
    logic s1_valid, s1_oob, s1_fwd;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= (state == INIT) ? clr_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx = (state == INIT && clr_cnt == LAST) ? RUN : state;
        busy     = (state == INIT);
    end

    assign en        = !(out_valid && !out_ready);
    assign rd_ready  = (state == RUN) && en;
    assign acc       = rd_valid && rd_ready;
    assign rd_in     = {1'b0, rd_addr} < LIM;
    assign wr_in     = {1'b0, wr_addr} < LIM;
    assign wr_take   = (state == RUN) && wr_en && wr_in;
    // clear writes share the single write port with run-time updates
    assign ram_we    = busy || wr_take;
    assign ram_waddr = busy ? clr_cnt : wr_addr;
    assign ram_wdata = busy ? INIT_VALUE : wr_data;

    // read port only fires on an in-range accept, so stalls and OOB reads leave rdata untouched
    threshold_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (acc && rd_in),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // RAM reads old data on a same-cycle collision; capture the write for write-first behaviour
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_oob   <= 1'b0;
            s1_fwd   <= 1'b0;
        end else if (en) begin
            s1_valid <= acc;
            s1_oob   <= !rd_in;
            s1_fwd   <= wr_take && wr_addr == rd_addr;
        end
        if (en) s1_fwd_data <= wr_data;
    end

    assign s1_data = s1_oob ? INIT_VALUE : (s1_fwd ? s1_fwd_data : ram_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_oob   <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_data  <= s1_data;
            out_oob   <= s1_oob;
        end
    end
endmodule

// File: tb/tb_threshold_table.sv
// tb_threshold_table: scoreboard-based directed bench for threshold_table (ADDR_W=5, DEPTH=20)
module tb_threshold_table;
    import threshold_pkg::*;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int DP = 20;
    localparam logic [7:0] IV = 8'h80;

    typedef struct packed { logic [DW-1:0] data; logic oob; } exp_t;

    logic clock = 1'b0;
    logic reset, rd_valid, rd_ready, out_valid, out_ready, out_oob, wr_en, busy;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] out_data, wr_data;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int first_acc = -1;
    int first_out = -1;
    logic accepted = 1'b0;
    logic hold_pending = 1'b0;
    logic [DW:0] hold_val;
    logic [DW-1:0] model [DP];
    exp_t sb [$];
    exp_t e;

    threshold_table #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .INIT_VALUE(IV)) dut (
        .clock(clock), .reset(reset), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_oob(out_oob),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock cycle: check outputs, record accepts into the scoreboard, update the model, advance
    task automatic tick();
        #1;
        if (hold_pending) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'({out_oob, out_data}), 32'(hold_val));
        end
        if (out_valid === 1'b1 && out_ready) begin
            if (first_out < 0) first_out = cyc;
            chk("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_oob", 32'(out_oob), 32'(e.oob));
            end
        end
        hold_pending = (out_valid === 1'b1) && !out_ready;
        hold_val = {out_oob, out_data};
        accepted = rd_valid && rd_ready === 1'b1;
        if (accepted) begin
            if (first_acc < 0) first_acc = cyc;
            e.oob = rd_addr >= AW'(DP);
            e.data = e.oob ? IV : (wr_en && wr_addr == rd_addr) ? wr_data : model[rd_addr];
            sb.push_back(e);
        end
        if (wr_en && busy === 1'b0 && wr_addr < AW'(DP)) model[wr_addr] = wr_data;
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        int n;
        out_ready = 1'b0;
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        hold_pending = 1'b0;
        first_acc = -1;
        first_out = -1;
        for (int i = 0; i < DP; i++) model[i] = IV;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_oob", 32'(out_oob), 0);
        chk("rst_rd_ready", 32'(rd_ready), 0);
        chk("rst_busy", 32'(busy), 1);
        out_ready = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("busy_cycles", 32'(n), DP);
    endtask

    task automatic rd(input int a);
        rd_valid = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = DW'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        rd_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 0);
        tick();
    endtask

    initial begin
        int nxt, k;
        reset = 1'b0; rd_valid = 1'b0; rd_addr = '0; out_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge clock);
        do_reset();
        // back-to-back reads of every entry after init
        for (int i = 0; i < DP; i++) begin
            rd_valid = 1'b1;
            rd_addr = AW'(i);
            #1 chk("rd_ready_run", 32'(rd_ready), 1);
            tick();
        end
        drain();
        chk("latency", 32'(first_out - first_acc), PIPE_DEPTH);
        // simple writes then reads
        wr(3, 8'h2A);
        wr(19, 8'hF0);
        rd(3); rd(19); rd(4);
        drain();
        // same-cycle collision, then a later write that must not affect that read
        rd_valid = 1'b1; rd_addr = 7; wr_en = 1'b1; wr_addr = 7; wr_data = 8'h11;
        tick();
        rd_valid = 1'b0;
        wr(7, 8'h22);
        drain();
        rd(7);
        drain();
        // out-of-range read, dropped write, reread, then full table check
        rd(25);
        wr(25, 8'h55);
        rd(25);
        for (int i = 0; i < DP; i++) rd(i);
        drain();
        // stalled stream of 10 reads
        nxt = 0;
        k = 0;
        while (nxt < 10 && k < 100) begin
            out_ready = (k % 3 == 0);
            rd_valid = 1'b1;
            rd_addr = AW'(nxt);
            tick();
            if (accepted) nxt++;
            k++;
        end
        chk("stall_accepts", 32'(nxt), 10);
        drain();
        // reset with reads in flight; written entry must return to default
        wr(3, 8'h2A);
        rd_valid = 1'b1; rd_addr = 0; tick();
        rd_addr = 1; tick();
        rd_valid = 1'b0;
        do_reset();
        rd(3);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
